// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;
  localparam int unsigned NR_DEF = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: array mux, same-cycle write forwarding and zero forcing.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic [DW-1:0] mem_i [(1 << AW)],
  input  logic          ready_i,
  input  logic          fwd_en_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] din_i,
  input  logic [AW-1:0] ra_i,
  output logic [DW-1:0] rd_data_o
);

  // Zero forcing has priority over forwarding so a dropped or not-ready read never leaks data.
  always_comb begin
    rd_data_o = mem_i[ra_i];
    if (BYPASS && fwd_en_i && (wa_i == ra_i)) begin
      rd_data_o = din_i;
    end
    if (!ready_i || (ZERO_R0 && (ra_i == '0))) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with an unreset array that is zeroed by an internal sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned NR      = NR_DEF,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             ready,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [DW-1:0]    din,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] dr
);

  localparam int unsigned DEPTH = 1 << AW;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_q, ready_d;

  logic          wr_drop_c;
  logic          wr_en_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic          fwd_en_c;

  logic [DW-1:0] mem_q [DEPTH];

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Next state: sweep every entry once, then run until a clear is requested.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ptr_d = '0;
        if (clr_req) begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs: single array write port shared by the sweep and user writes.
  always_comb begin
    ready_d   = (state_d == RUN);
    wr_drop_c = ZERO_R0 && (wa == '0);
    wr_en_c   = 1'b0;
    wr_addr_c = wa;
    wr_data_c = din;
    case (state_q)
      CLEAR: begin
        wr_en_c   = 1'b1;
        wr_addr_c = ptr_q;
        wr_data_c = '0;
      end
      RUN: begin
        wr_en_c = we && !wr_drop_c;
      end
      default: begin
        wr_en_c = 1'b0;
      end
    endcase
    fwd_en_c = ready_q && we && !wr_drop_c;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_addr_c] <= wr_data_c;
    end
  end

  assign ready = ready_q;

  for (genvar g = 0; g < NR; g++) begin : g_rd
    regfile_rdport #(
      .DW      (DW),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .mem_i     (mem_q),
      .ready_i   (ready_q),
      .fwd_en_i  (fwd_en_c),
      .wa_i      (wa),
      .din_i     (din),
      .ra_i      (ra[g*AW +: AW]),
      .rd_data_o (dr[g*DW +: DW])
    );
  end

endmodule
